// File: rtl/issue_ctrl.sv
// issue_ctrl -- issue stage between decode and execute.
//
// Accepts one decoded instruction per cycle over a valid/ready handshake and
// registers it toward execute. Issue is held for:
//   RAW hazards / WAW counter saturation (s_stall_o = 1),
//   a busy multi-cycle MDU                 (s_stall_o = 2),
//   CSR serialization (drain / wait)        (s_stall_o = 3).
// Register writes in flight are tracked by a per-register pending counter,
// incremented on issue and decremented by writeback release pulses.
//
// Ports:
//   s_clk_i, s_reset_i          clock, synchronous active-high reset
//   s_id_*                      decoded instruction + handshake from decode
//   s_ex_*                      registered instruction + handshake to execute
//   s_flush_i                   squash output register and CSR sequencing
//   s_rel_valid_i/s_rel_rd_i    writeback release of one register write
//   s_mdu_done_i, s_csr_done_i  MDU finished / CSR left pipeline
//   s_stall_o                   stall cause, s_sb_err_o sticky release-underflow
//
// Build option: define ISSUE_BYPASS_EN to let a same-cycle release lower the
// effective pending count used by the RAW/WAW check.
//
// Field encodings: sctrl bits {ZERO2,ZERO1,RFRP2,RFRP1} = [3:0];
// ictrl bit 3 = UNIT_MDU, bit 4 = UNIT_CSR, bit 7 = REG_DEST;
// imiscon 0 = FREE (no misconduct), nonzero = misconduct (e.g. 1 = ILLE).

module issue_ctrl #(
    parameter int unsigned PEND_W = 2
) (
    input  logic        s_clk_i,
    input  logic        s_reset_i,
    input  logic        s_id_valid_i,
    output logic        s_id_ready_o,
    input  logic [4:0]  s_rs1_i,
    input  logic [4:0]  s_rs2_i,
    input  logic [4:0]  s_rd_i,
    input  logic [3:0]  s_sctrl_i,
    input  logic [7:0]  s_ictrl_i,
    input  logic [2:0]  s_imiscon_i,
    input  logic [20:0] s_payload_i,
    input  logic [3:0]  s_f_i,
    output logic        s_ex_valid_o,
    input  logic        s_ex_ready_i,
    output logic [4:0]  s_ex_rs1_o,
    output logic [4:0]  s_ex_rs2_o,
    output logic [4:0]  s_ex_rd_o,
    output logic [3:0]  s_ex_sctrl_o,
    output logic [7:0]  s_ex_ictrl_o,
    output logic [2:0]  s_ex_imiscon_o,
    output logic [20:0] s_ex_payload_o,
    output logic [3:0]  s_ex_f_o,
    input  logic        s_flush_i,
    input  logic        s_rel_valid_i,
    input  logic [4:0]  s_rel_rd_i,
    input  logic        s_mdu_done_i,
    input  logic        s_csr_done_i,
    output logic [1:0]  s_stall_o,
    output logic        s_sb_err_o
);

    localparam int unsigned SCTRL_RFRP1    = 0;
    localparam int unsigned SCTRL_RFRP2    = 1;
    localparam int unsigned SCTRL_ZERO1    = 2;
    localparam int unsigned SCTRL_ZERO2    = 3;
    localparam int unsigned ICTRL_UNIT_MDU = 3;
    localparam int unsigned ICTRL_UNIT_CSR = 4;
    localparam int unsigned ICTRL_REG_DEST = 7;
    localparam logic [2:0]  IMISCON_FREE   = 3'd0;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {ST_NORMAL, ST_DRAIN, ST_CSR_WAIT} state_t;

    state_t            state, state_nx;
    logic [PEND_W-1:0] pend [32];
    logic              mdu_busy;

    logic              free, use1, use2, wr, csr_ins, mdu_ins;
    logic [PEND_W-1:0] eff_rs1, eff_rs2, eff_rd;
    logic              any_pend, csr_clear, hazard, mdu_stall, fsm_ok;
    logic              accept, rel_hit;

    // ---------------------------------------------------------------- decode
    assign free    = (s_imiscon_i == IMISCON_FREE);
    assign use1    = s_sctrl_i[SCTRL_RFRP1] & ~s_sctrl_i[SCTRL_ZERO1] & (s_rs1_i != '0);
    assign use2    = s_sctrl_i[SCTRL_RFRP2] & ~s_sctrl_i[SCTRL_ZERO2] & (s_rs2_i != '0);
    assign wr      = s_ictrl_i[ICTRL_REG_DEST] & (s_rd_i != '0) & free;
    assign csr_ins = free & s_ictrl_i[ICTRL_UNIT_CSR];
    assign mdu_ins = free & s_ictrl_i[ICTRL_UNIT_MDU];
    assign rel_hit = s_rel_valid_i & (s_rel_rd_i != '0);

    // Effective counts seen by the hazard check.
    always_comb begin
        eff_rs1 = pend[s_rs1_i];
        eff_rs2 = pend[s_rs2_i];
        eff_rd  = pend[s_rd_i];
`ifdef ISSUE_BYPASS_EN
        // A release landing this cycle already frees one writer.
        if (rel_hit && s_rel_rd_i == s_rs1_i && eff_rs1 != '0) eff_rs1 = eff_rs1 - PEND_W'(1);
        if (rel_hit && s_rel_rd_i == s_rs2_i && eff_rs2 != '0) eff_rs2 = eff_rs2 - PEND_W'(1);
        if (rel_hit && s_rel_rd_i == s_rd_i  && eff_rd  != '0) eff_rd  = eff_rd  - PEND_W'(1);
`endif
    end

    always_comb begin
        any_pend = 1'b0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (pend[i[4:0]] != '0) any_pend = 1'b1;
        end
    end

    assign csr_clear = ~any_pend & ~s_ex_valid_o & ~mdu_busy;
    assign hazard    = free & ((use1 & (eff_rs1 != '0)) |
                               (use2 & (eff_rs2 != '0)) |
                               (wr   & (eff_rd == PEND_MAX)));
    // A done pulse frees the MDU for an instruction issuing in the same cycle.
    assign mdu_stall = mdu_ins & mdu_busy & ~s_mdu_done_i;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) state <= ST_NORMAL;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (s_flush_i) begin
            state_nx = ST_NORMAL;
        end else begin
            case (state)
                ST_NORMAL:   if (s_id_valid_i && csr_ins) state_nx = accept ? ST_CSR_WAIT : ST_DRAIN;
                ST_DRAIN:    if (accept) state_nx = ST_CSR_WAIT;
                ST_CSR_WAIT: if (s_csr_done_i) state_nx = ST_NORMAL;
                default:     state_nx = ST_NORMAL;
            endcase
        end
    end

    always_comb begin
        case (state)
            ST_NORMAL: fsm_ok = ~csr_ins | csr_clear;
            ST_DRAIN:  fsm_ok = csr_ins & csr_clear;
            default:   fsm_ok = 1'b0;
        endcase
    end

    assign s_id_ready_o = ~s_flush_i & (~s_ex_valid_o | s_ex_ready_i) &
                          ~hazard & ~mdu_stall & fsm_ok;
    assign accept       = s_id_valid_i & s_id_ready_o;

    always_comb begin
        if (!s_id_valid_i)  s_stall_o = 2'd0;
        else if (!fsm_ok)   s_stall_o = 2'd3;
        else if (hazard)    s_stall_o = 2'd1;
        else if (mdu_stall) s_stall_o = 2'd2;
        else                s_stall_o = 2'd0;
    end

    // ------------------------------------------------------- output register
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            s_ex_valid_o   <= 1'b0;
            s_ex_rs1_o     <= '0;
            s_ex_rs2_o     <= '0;
            s_ex_rd_o      <= '0;
            s_ex_sctrl_o   <= '0;
            s_ex_ictrl_o   <= '0;
            s_ex_imiscon_o <= '0;
            s_ex_payload_o <= '0;
            s_ex_f_o       <= '0;
        end else if (s_flush_i) begin
            s_ex_valid_o <= 1'b0;
        end else if (accept) begin
            s_ex_valid_o   <= 1'b1;
            s_ex_rs1_o     <= s_rs1_i;
            s_ex_rs2_o     <= s_rs2_i;
            s_ex_rd_o      <= s_rd_i;
            s_ex_sctrl_o   <= s_sctrl_i;
            s_ex_ictrl_o   <= s_ictrl_i;
            s_ex_imiscon_o <= s_imiscon_i;
            s_ex_payload_o <= s_payload_i;
            s_ex_f_o       <= s_f_i;
        end else if (s_ex_ready_i) begin
            s_ex_valid_o <= 1'b0;
        end
    end

    // ------------------------------------------------------------ scoreboard
    // Flush does not touch the counters: squashed work is still released.
    always_ff @(posedge s_clk_i) begin
        if (s_reset_i) begin
            for (int unsigned i = 0; i < 32; i++) pend[i[4:0]] <= '0;
            s_sb_err_o <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (accept && wr && s_rd_i == i[4:0]) begin
                    if (!(rel_hit && s_rel_rd_i == i[4:0]))
                        pend[i[4:0]] <= pend[i[4:0]] + PEND_W'(1);
                end else if (rel_hit && s_rel_rd_i == i[4:0]) begin
                    if (pend[i[4:0]] == '0) s_sb_err_o <= 1'b1;
                    else                    pend[i[4:0]] <= pend[i[4:0]] - PEND_W'(1);
                end
            end
        end
    end

    always_ff @(posedge s_clk_i) begin
        if (s_reset_i)                mdu_busy <= 1'b0;
        else if (accept && mdu_ins)   mdu_busy <= 1'b1;
        else if (s_mdu_done_i)        mdu_busy <= 1'b0;
    end

endmodule

// File: tb/tb_issue_ctrl.sv
module tb_issue_ctrl;

    localparam int PEND_W = 2;
    localparam int MAXC   = (1 << PEND_W) - 1;
`ifdef ISSUE_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam logic [7:0] I_ADD = 8'h81;
    localparam logic [7:0] I_LSU = 8'h84;
    localparam logic [7:0] I_MDU = 8'h88;
    localparam logic [7:0] I_CSR = 8'h90;
    localparam logic [2:0] IM_FREE = 3'd0;
    localparam logic [2:0] IM_ILLE = 3'd1;

    typedef struct packed {
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  sctrl;
        logic [7:0]  ictrl;
        logic [2:0]  imiscon;
        logic [20:0] payload;
        logic [3:0]  f;
    } ins_t;

    logic clk, reset;
    logic s_id_valid_i, s_id_ready_o, s_ex_valid_o, s_ex_ready_i, s_flush_i;
    logic [4:0] s_rs1_i, s_rs2_i, s_rd_i, s_ex_rs1_o, s_ex_rs2_o, s_ex_rd_o, s_rel_rd_i;
    logic [3:0] s_sctrl_i, s_ex_sctrl_o, s_f_i, s_ex_f_o;
    logic [7:0] s_ictrl_i, s_ex_ictrl_o;
    logic [2:0] s_imiscon_i, s_ex_imiscon_o;
    logic [20:0] s_payload_i, s_ex_payload_o;
    logic s_rel_valid_i, s_mdu_done_i, s_csr_done_i, s_sb_err_o;
    logic [1:0] s_stall_o;

    issue_ctrl #(.PEND_W(PEND_W)) dut (
        .s_clk_i(clk), .s_reset_i(reset),
        .s_id_valid_i(s_id_valid_i), .s_id_ready_o(s_id_ready_o),
        .s_rs1_i(s_rs1_i), .s_rs2_i(s_rs2_i), .s_rd_i(s_rd_i),
        .s_sctrl_i(s_sctrl_i), .s_ictrl_i(s_ictrl_i), .s_imiscon_i(s_imiscon_i),
        .s_payload_i(s_payload_i), .s_f_i(s_f_i),
        .s_ex_valid_o(s_ex_valid_o), .s_ex_ready_i(s_ex_ready_i),
        .s_ex_rs1_o(s_ex_rs1_o), .s_ex_rs2_o(s_ex_rs2_o), .s_ex_rd_o(s_ex_rd_o),
        .s_ex_sctrl_o(s_ex_sctrl_o), .s_ex_ictrl_o(s_ex_ictrl_o),
        .s_ex_imiscon_o(s_ex_imiscon_o), .s_ex_payload_o(s_ex_payload_o), .s_ex_f_o(s_ex_f_o),
        .s_flush_i(s_flush_i), .s_rel_valid_i(s_rel_valid_i), .s_rel_rd_i(s_rel_rd_i),
        .s_mdu_done_i(s_mdu_done_i), .s_csr_done_i(s_csr_done_i),
        .s_stall_o(s_stall_o), .s_sb_err_o(s_sb_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus state and reference model state.
    ins_t cur;
    bit v, fl, exr, relv, mdone, cdone;
    logic [4:0] relrd;
    ins_t expq[$];     // instruction expected in the execute register
    int cnt[32];       // writes in flight per register
    bit m_mdu, m_err;
    int phase;         // 0 free to issue, 1 CSR waiting for quiet pipe, 2 CSR in flight
    bit dut_acc, mon_en;
    int last_stall, checks, failures, lat;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_out();
        ins_t o;
        o = '{s_ex_rs1_o, s_ex_rs2_o, s_ex_rd_o, s_ex_sctrl_o, s_ex_ictrl_o,
              s_ex_imiscon_o, s_ex_payload_o, s_ex_f_o};
        return 64'(o);
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) cnt[r] = 0;
        m_mdu = 0; m_err = 0; phase = 0;
        expq.delete();
    endtask

    function automatic int eff(input int r);
        if (BYP != 0 && relv && relrd != 0 && int'(relrd) == r && cnt[r] > 0) return cnt[r] - 1;
        return cnt[r];
    endfunction

    // Issue rules evaluated directly from the current inputs and model state.
    task automatic predict(output bit rdy, output int st);
        bit free, u1, u2, w, csr, mdu, quiet, raw, mblk, cblk;
        int total;
        free = (cur.imiscon == IM_FREE);
        u1 = cur.sctrl[0] && !cur.sctrl[2] && cur.rs1 != 0;
        u2 = cur.sctrl[1] && !cur.sctrl[3] && cur.rs2 != 0;
        w  = cur.ictrl[7] && cur.rd != 0 && free;
        csr = free && cur.ictrl[4];
        mdu = free && cur.ictrl[3];
        total = 0;
        for (int r = 0; r < 32; r++) total += cnt[r];
        quiet = (total == 0) && (expq.size() == 0) && !m_mdu;
        raw  = free && ((u1 && eff(int'(cur.rs1)) > 0) || (u2 && eff(int'(cur.rs2)) > 0) ||
                        (w && eff(int'(cur.rd)) >= MAXC));
        mblk = mdu && m_mdu && !mdone;
        cblk = (phase == 2) || (phase == 1 && !(csr && quiet)) || (phase == 0 && csr && !quiet);
        rdy  = !fl && (expq.size() == 0 || exr) && !raw && !mblk && !cblk;
        st   = !v ? 0 : cblk ? 3 : raw ? 1 : mblk ? 2 : 0;
    endtask

    task automatic update(input bit acc);
        bit free, w, csr, mdu, inc, dec;
        free = (cur.imiscon == IM_FREE);
        w    = cur.ictrl[7] && cur.rd != 0 && free;
        csr  = free && cur.ictrl[4];
        mdu  = free && cur.ictrl[3];
        inc  = acc && w;
        dec  = relv && relrd != 0;
        if (!(inc && dec && cur.rd == relrd)) begin
            if (inc) cnt[cur.rd]++;
            if (dec) begin
                if (cnt[relrd] == 0) m_err = 1;
                else cnt[relrd]--;
            end
        end
        if (acc && mdu) m_mdu = 1;
        else if (mdone) m_mdu = 0;
        if (fl) phase = 0;
        else if (phase == 0 && v && csr) phase = acc ? 2 : 1;
        else if (phase == 1 && acc) phase = 2;
        else if (phase == 2 && cdone) phase = 0;
        if (fl) expq.delete();
        else if (acc) begin expq.delete(); expq.push_back(cur); end
        else if (exr && expq.size() != 0) void'(expq.pop_front());
    endtask

    task automatic drive();
        s_id_valid_i = v; s_flush_i = fl; s_ex_ready_i = exr;
        s_rel_valid_i = relv; s_rel_rd_i = relrd;
        s_mdu_done_i = mdone; s_csr_done_i = cdone;
        s_rs1_i = cur.rs1; s_rs2_i = cur.rs2; s_rd_i = cur.rd;
        s_sctrl_i = cur.sctrl; s_ictrl_i = cur.ictrl; s_imiscon_i = cur.imiscon;
        s_payload_i = cur.payload; s_f_i = cur.f;
    endtask

    // One clock: drive, check handshake outputs against the model, advance.
    task automatic step();
        bit rdy;
        int st;
        drive();
        #1;
        predict(rdy, st);
        chk("id_ready", int'(s_id_ready_o), int'(rdy));
        chk("stall", int'(s_stall_o), st);
        chk("sb_err", int'(s_sb_err_o), int'(m_err));
        dut_acc = v && s_id_ready_o;
        last_stall = int'(s_stall_o);
        @(posedge clk);
        #1;
        update(v && rdy);
    endtask

    task automatic idle();
        v = 0; fl = 0; exr = 1; relv = 0; relrd = '0; mdone = 0; cdone = 0;
    endtask

    task automatic set_ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [3:0] sc, input logic [7:0] ic, input logic [2:0] im);
        cur = '{rs1, rs2, rd, sc, ic, im, 21'($urandom), 4'($urandom)};
        v = 1;
    endtask

    task automatic release_reg(input logic [4:0] r);
        idle(); relv = 1; relrd = r; step(); idle();
    endtask

    // Waits for the held instruction to issue; lat counts the extra cycles.
    task automatic wait_issue();
        lat = 0;
        while (!dut_acc && lat < 6) begin step(); lat++; end
        idle();
    endtask

    task automatic rand_cycle();
        int u, b;
        int cand[$];
        v = ($urandom_range(0, 3) != 0);
        u = $urandom_range(0, 9);
        b = (u < 5) ? 0 : (u < 7) ? 2 : (u < 9) ? 3 : 4;
        cur.rs1 = 5'($urandom_range(0, 7));
        cur.rs2 = 5'($urandom_range(0, 7));
        cur.rd  = 5'($urandom_range(0, 7));
        cur.sctrl = 4'($urandom);
        cur.ictrl = 8'(1 << b);
        if ($urandom_range(0, 9) < 7) cur.ictrl[7] = 1'b1;
        cur.imiscon = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(1, 7)) : IM_FREE;
        cur.payload = 21'($urandom);
        cur.f = 4'($urandom);
        exr = ($urandom_range(0, 3) != 0);
        fl  = ($urandom_range(0, 39) == 0);
        for (int r = 1; r < 32; r++) if (cnt[r] > 0) cand.push_back(r);
        if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
            relv = 1; relrd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
        end else begin
            relv = ($urandom_range(0, 15) == 0); relrd = '0;
        end
        mdone = m_mdu && ($urandom_range(0, 2) == 0);
        cdone = (phase == 2) && ($urandom_range(0, 2) == 0);
        step();
    endtask

    // Monitor: whenever execute sees a valid instruction it must be the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ex_valid", int'(s_ex_valid_o), int'(expq.size() != 0));
            if (s_ex_valid_o && expq.size() != 0) chk_w("ex_fields", dut_out(), 64'(expq[0]));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; mon_en = 0;
        cur = '0; idle(); model_reset();
        reset = 1; drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ex_valid", int'(s_ex_valid_o), 0);
        chk_w("rst_ex_fields", dut_out(), 64'd0);
        chk("rst_sb_err", int'(s_sb_err_o), 0);
        reset = 0; mon_en = 1;

        // RAW hold and release latency.
        set_ins(5'd1, 5'd2, 5'd5, 4'b0011, I_ADD, IM_FREE); step();
        chk("add1_issue", int'(dut_acc), 1);
        set_ins(5'd5, 5'd3, 5'd6, 4'b0011, I_ADD, IM_FREE); step();
        chk("raw_stall", last_stall, 1);
        chk("raw_hold", int'(dut_acc), 0);
        relv = 1; relrd = 5'd5; step(); relv = 0;
        wait_issue();
        chk("raw_release_latency", lat, (BYP != 0) ? 0 : 1);
        release_reg(5'd6);

        // WAW saturation on x7.
        for (int i = 0; i < 3; i++) begin
            set_ins(5'd0, 5'd0, 5'd7, 4'b0000, I_ADD, IM_FREE); step();
            chk("waw_fill", int'(dut_acc), 1);
        end
        set_ins(5'd0, 5'd0, 5'd7, 4'b0000, I_ADD, IM_FREE); step();
        chk("waw_stall", last_stall, 1);
        relv = 1; relrd = 5'd7; step(); relv = 0;
        wait_issue();
        chk("waw_release_latency", lat, (BYP != 0) ? 0 : 1);
        set_ins(5'd0, 5'd0, 5'd7, 4'b0000, I_ADD, IM_FREE); step();
        chk("waw_full_again", last_stall, 1);
        for (int i = 0; i < 3; i++) release_reg(5'd7);

        // MDU busy.
        set_ins(5'd1, 5'd2, 5'd10, 4'b0011, I_MDU, IM_FREE); step();
        chk("mul_issue", int'(dut_acc), 1);
        set_ins(5'd3, 5'd4, 5'd11, 4'b0011, I_MDU, IM_FREE); step();
        chk("mdu_stall", last_stall, 2);
        step();
        chk("mdu_stall_hold", last_stall, 2);
        mdone = 1; step(); mdone = 0;
        chk("div_in_done_cycle", int'(dut_acc), 1);
        set_ins(5'd1, 5'd2, 5'd14, 4'b0011, I_MDU, IM_FREE); step();
        chk("mdu_still_busy", last_stall, 2);
        idle(); mdone = 1; step(); idle();
        release_reg(5'd10); release_reg(5'd11);

        // CSR serialization behind a pending load.
        set_ins(5'd1, 5'd0, 5'd9, 4'b0001, I_LSU, IM_FREE); step();
        chk("load_issue", int'(dut_acc), 1);
        set_ins(5'd1, 5'd0, 5'd12, 4'b0001, I_CSR, IM_FREE); step();
        chk("csr_drain_stall", last_stall, 3);
        step();
        chk("csr_drain_hold", last_stall, 3);
        relv = 1; relrd = 5'd9; step(); relv = 0;
        wait_issue();
        chk("csr_issue_after_release", lat, 1);
        set_ins(5'd1, 5'd2, 5'd15, 4'b0011, I_ADD, IM_FREE); step();
        chk("csr_wait_stall", last_stall, 3);
        cdone = 1; step(); cdone = 0;
        chk("csr_done_cycle_hold", int'(dut_acc), 0);
        step();
        chk("add_after_csr", int'(dut_acc), 1);
        idle();
        release_reg(5'd12); release_reg(5'd15);

        // Misconduct bypass, then flush with stalled output.
        set_ins(5'd1, 5'd0, 5'd13, 4'b0001, I_LSU, IM_FREE); step();
        set_ins(5'd13, 5'd13, 5'd13, 4'b0011, I_ADD, IM_ILLE); step();
        chk("ille_issue", int'(dut_acc), 1);
        chk("ille_no_stall", last_stall, 0);
        set_ins(5'd13, 5'd0, 5'd16, 4'b0001, I_ADD, IM_FREE); step();
        chk("one_pending_after_ille", last_stall, 1);
        idle(); release_reg(5'd13);
        set_ins(5'd13, 5'd0, 5'd16, 4'b0001, I_ADD, IM_FREE); step();
        chk("issue_after_single_release", int'(dut_acc), 1);
        idle(); release_reg(5'd16);
        set_ins(5'd1, 5'd2, 5'd17, 4'b0011, I_ADD, IM_FREE); exr = 0; step();
        idle(); exr = 0; step();
        chk("ex_hold", int'(s_ex_valid_o), 1);
        exr = 0; fl = 1; step();
        chk("flush_clears_valid", int'(s_ex_valid_o), 0);
        idle(); release_reg(5'd17);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) rand_cycle();

        // Drain everything, then underflow x4.
        idle(); mdone = 1; cdone = 1; step(); idle();
        for (int r = 1; r < 32; r++) while (cnt[r] > 0) release_reg(5'(r));
        chk("sb_err_clear_before", int'(s_sb_err_o), 0);
        release_reg(5'd4);
        chk("sb_err_set", int'(s_sb_err_o), 1);
        for (int i = 0; i < 20; i++) rand_cycle();
        chk("sb_err_sticky", int'(s_sb_err_o), 1);

        // Reset in the middle of traffic.
        reset = 1; relv = 1; relrd = 5'd3; v = 1; drive();
        @(posedge clk);
        #1;
        model_reset();
        chk("mid_rst_ex_valid", int'(s_ex_valid_o), 0);
        chk_w("mid_rst_ex_fields", dut_out(), 64'd0);
        chk("mid_rst_sb_err", int'(s_sb_err_o), 0);
        reset = 0; idle(); step();
        for (int i = 0; i < 200; i++) rand_cycle();

        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
